// File: rtl/sm_step_ctrl.sv
// Run/step controller: conditions the raw step button and run switch and
// drives the clock enable of sm_top with single, auto-repeated or free-run enables.
module sm_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic        stepKey_n,
  input  logic        runSw,
  input  logic [4:0]  pulseShift,
  output logic        clkEnable,
  output logic        stepPulse,
  output logic [15:0] stepCount,
  output logic        keyDeb,
  output logic        runDeb
);

  localparam int              DEB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
  localparam logic [31:0]     HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0]     REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PULSE       = 2'd1;
  localparam logic [1:0] HOLD_WAIT   = 2'd2;
  localparam logic [1:0] REPEAT_WAIT = 2'd3;

  logic             key_meta, key_sync;
  logic             run_meta, run_sync;
  logic [DEB_W-1:0] key_cnt, run_cnt;
  logic             key_deb_q;
  logic             key_rise;
  logic [1:0]       state;
  logic             first;
  logic [4:0]       shift_q;
  logic [31:0]      timer;
  logic [31:0]      pulse_last;
  logic [31:0]      wait_last;

  // Synchronizers come out of reset in the released position so no phantom press appears.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      run_meta <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      key_meta <= stepKey_n;
      key_sync <= key_meta;
      run_meta <= runSw;
      run_sync <= run_meta;
    end
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      key_cnt <= '0;
      keyDeb  <= 1'b0;
    end else if (!key_sync != keyDeb) begin
      if (key_cnt == DEB_LAST) begin
        keyDeb  <= ~keyDeb;
        key_cnt <= '0;
      end else begin
        key_cnt <= key_cnt + DEB_ONE;
      end
    end else begin
      key_cnt <= '0;
    end
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      runDeb  <= 1'b0;
    end else if (run_sync != runDeb) begin
      if (run_cnt == DEB_LAST) begin
        runDeb  <= ~runDeb;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + DEB_ONE;
      end
    end else begin
      run_cnt <= '0;
    end
  end

  assign key_rise   = keyDeb & ~key_deb_q;
  assign pulse_last = (32'd1 << shift_q) - 32'd1;
  assign wait_last  = (state == HOLD_WAIT) ? HOLD_LAST : REPEAT_LAST;
  assign clkEnable  = runDeb | (state == PULSE);

  // A pulse always runs to completion; the key level is only consulted once it ends.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      first     <= 1'b0;
      shift_q   <= '0;
      timer     <= '0;
      stepPulse <= 1'b0;
      stepCount <= '0;
      key_deb_q <= 1'b0;
    end else begin
      stepPulse <= 1'b0;
      key_deb_q <= keyDeb;
      if (runDeb) begin
        state <= IDLE;
        timer <= '0;
        first <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (key_rise) begin
              state     <= PULSE;
              first     <= 1'b1;
              shift_q   <= pulseShift;
              stepPulse <= 1'b1;
              stepCount <= stepCount + 16'd1;
            end
          end
          PULSE: begin
            if (timer == pulse_last) begin
              timer <= '0;
              if (!keyDeb)
                state <= IDLE;
              else if (first)
                state <= HOLD_WAIT;
              else
                state <= REPEAT_WAIT;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          HOLD_WAIT, REPEAT_WAIT: begin
            if (!keyDeb) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == wait_last) begin
              state     <= PULSE;
              timer     <= '0;
              first     <= 1'b0;
              shift_q   <= pulseShift;
              stepPulse <= 1'b1;
              stepCount <= stepCount + 16'd1;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Directed bench for sm_step_ctrl with short debounce/hold/repeat times;
// every cycle of each press window is compared against hand-derived timings.
module tb_sm_step_ctrl;

  logic        clkIn = 1'b0;
  logic        rst_n = 1'b0;
  logic        stepKey_n = 1'b1;
  logic        runSw = 1'b0;
  logic [4:0]  pulseShift = 5'd2;
  logic        clkEnable;
  logic        stepPulse;
  logic [15:0] stepCount;
  logic        keyDeb;
  logic        runDeb;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_count = 16'h0000;
  int          exp_starts[$];

  sm_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(10)
  ) dut (
    .clkIn(clkIn),
    .rst_n(rst_n),
    .stepKey_n(stepKey_n),
    .runSw(runSw),
    .pulseShift(pulseShift),
    .clkEnable(clkEnable),
    .stepPulse(stepPulse),
    .stepCount(stepCount),
    .keyDeb(keyDeb),
    .runDeb(runDeb)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Edge 0 is the edge right before the key goes low; k counts edges after it.
  // Pulse start edges come from exp_starts; the debounced levels follow 6 edges behind raw.
  task automatic applyStimulus(input string tag, input int cycles, input int width,
                               input int bounce_until, input int release_at,
                               input int run_on, input int run_off, input int shift_poke_at);
    logic exp_pulse, exp_en, exp_run, exp_key;
    @(posedge clkIn);
    #1;
    stepKey_n = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clkIn);
      #1;
      exp_pulse = 1'b0;
      exp_en    = 1'b0;
      foreach (exp_starts[i]) begin
        if (k == exp_starts[i]) exp_pulse = 1'b1;
        if (k >= exp_starts[i] && k < exp_starts[i] + width) exp_en = 1'b1;
      end
      exp_run = (run_on > 0) && (k >= run_on + 6) && (k <= run_off + 5);
      if (exp_run) exp_en = 1'b1;
      exp_key = (k >= bounce_until + 6) && (k < release_at + 6);
      if (exp_pulse) exp_count++;
      checkOutput($sformatf("%s k=%0d clkEnable", tag, k), 32'(clkEnable), 32'(exp_en));
      checkOutput($sformatf("%s k=%0d stepPulse", tag, k), 32'(stepPulse), 32'(exp_pulse));
      checkOutput($sformatf("%s k=%0d keyDeb", tag, k), 32'(keyDeb), 32'(exp_key));
      checkOutput($sformatf("%s k=%0d runDeb", tag, k), 32'(runDeb), 32'(exp_run));
      checkOutput($sformatf("%s k=%0d stepCount", tag, k), 32'(stepCount), 32'(exp_count));
      if (k < bounce_until)
        stepKey_n = ((k / 2) % 2) != 0;
      else
        stepKey_n = (k >= release_at);
      if (k == run_on) runSw = 1'b1;
      if (k == run_off) runSw = 1'b0;
      if (k == shift_poke_at) pulseShift = 5'd4;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #23;
    checkOutput("reset clkEnable", 32'(clkEnable), 32'd0);
    checkOutput("reset stepPulse", 32'(stepPulse), 32'd0);
    checkOutput("reset stepCount", 32'(stepCount), 32'd0);
    checkOutput("reset keyDeb", 32'(keyDeb), 32'd0);
    checkOutput("reset runDeb", 32'(runDeb), 32'd0);
    @(negedge clkIn);
    rst_n = 1'b1;
    repeat (3) @(posedge clkIn);

    pulseShift = 5'd2;
    exp_starts = '{7};
    applyStimulus("single", 40, 4, 0, 15, 0, 0, 0);

    exp_starts = '{19};
    applyStimulus("bounce", 50, 4, 12, 30, 0, 0, 0);

    exp_starts = '{7, 31, 45, 59, 73, 87, 101};
    applyStimulus("repeat", 130, 4, 0, 100, 0, 0, 0);

    exp_starts = '{7};
    applyStimulus("run", 70, 4, 0, 50, 14, 34, 0);

    pulseShift = 5'd3;
    applyStimulus("wide", 30, 8, 0, 9, 0, 0, 0);

    pulseShift = 5'd0;
    applyStimulus("narrow", 30, 1, 0, 9, 0, 0, 0);

    // Wrap: preload the counter, then one press; width poke mid-pulse must not stretch it.
    pulseShift = 5'd2;
    @(posedge clkIn);
    #1;
    force dut.stepCount = 16'hFFFF;
    #1;
    release dut.stepCount;
    #1;
    exp_count = 16'hFFFF;
    checkOutput("wrap preload", 32'(stepCount), 32'(exp_count));
    applyStimulus("wrap", 30, 4, 0, 9, 0, 0, 8);
    checkOutput("wrap zero", 32'(stepCount), 32'h0000);
    pulseShift = 5'd2;

    // Reset on the second cycle of a pulse clears everything without a clock edge.
    @(posedge clkIn);
    #1;
    stepKey_n = 1'b0;
    repeat (8) @(posedge clkIn);
    #1;
    checkOutput("pre-reset clkEnable", 32'(clkEnable), 32'd1);
    checkOutput("pre-reset stepCount", 32'(stepCount), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset clkEnable", 32'(clkEnable), 32'd0);
    checkOutput("async reset stepCount", 32'(stepCount), 32'd0);
    checkOutput("async reset keyDeb", 32'(keyDeb), 32'd0);
    checkOutput("async reset stepPulse", 32'(stepPulse), 32'd0);
    stepKey_n = 1'b1;
    repeat (2) @(posedge clkIn);
    @(negedge clkIn);
    rst_n = 1'b1;
    repeat (3) @(posedge clkIn);
    exp_count = 16'h0000;
    exp_starts = '{7};
    applyStimulus("after reset", 40, 4, 0, 15, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
